// File: rtl/sfr_reg_file_param.sv
// Special-function register file: NREG data registers at BASE..BASE+NREG-1 with
// atomic read-modify-write ops, a sticky write-protect register, and bypassed registered reads.
module sfr_reg_file_param #(
  parameter int unsigned     AW      = 8,
  parameter int unsigned     DW      = 10,
  parameter int unsigned     NREG    = 5,
  parameter int unsigned     BASE    = 'h81,
  parameter logic [DW-1:0]   RST_VAL = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic [DW-1:0]        wr_data,
  input  logic [1:0]           wr_op,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic [DW-1:0]        rd_data,
  output logic                 rd_valid,
  output logic                 wr_err,
  output logic                 rd_err,
  output logic [NREG-1:0]      prot,
  output logic [NREG*DW-1:0]   regs_flat
);

  if (NREG < 1 || NREG > DW) begin : g_bad_nreg
    $error("sfr_reg_file_param: NREG must be in 1..DW");
  end
  if ((64'(BASE) + 64'(NREG)) > ((64'd1 << AW) - 64'd1)) begin : g_bad_base
    $error("sfr_reg_file_param: BASE+NREG exceeds the address space");
  end

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  localparam logic [AW-1:0] PROT_ADDR = AW'(BASE + NREG);

  logic [DW-1:0]   regs_q [NREG];
  logic [DW-1:0]   regs_d [NREG];
  logic [NREG-1:0] prot_q, prot_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            rd_valid_q;
  logic            rd_err_q, rd_err_d;
  logic            wr_err_q, wr_err_d;
  logic            wr_hit, rd_hit;

  function automatic logic [DW-1:0] apply_op(input op_e op, input logic [DW-1:0] cur,
                                             input logic [DW-1:0] opnd);
    case (op)
      OP_WRITE:  apply_op = opnd;
      OP_SET:    apply_op = cur | opnd;
      OP_CLEAR:  apply_op = cur & ~opnd;
      OP_TOGGLE: apply_op = cur ^ opnd;
      default:   apply_op = cur;
    endcase
  endfunction

  always_comb begin
    regs_d   = regs_q;
    prot_d   = prot_q;
    wr_err_d = 1'b0;
    wr_hit   = 1'b0;
    if (wr_en) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (wr_addr == AW'(BASE + i)) begin
          wr_hit = 1'b1;
          if (prot_q[i]) wr_err_d = 1'b1;
          else           regs_d[i] = apply_op(op_e'(wr_op), regs_q[i], wr_data);
        end
      end
      if (wr_addr == PROT_ADDR) begin
        wr_hit = 1'b1;
        prot_d = prot_q | wr_data[NREG-1:0];
      end
      if (!wr_hit) wr_err_d = 1'b1;
    end
  end

  // Reads sample the next-state values so a same-cycle write is bypassed;
  // a rejected write leaves regs_d equal to regs_q, returning the old value.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_err_d  = 1'b0;
    rd_hit    = 1'b0;
    if (rd_en) begin
      rd_data_d = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
        if (rd_addr == AW'(BASE + i)) begin
          rd_hit    = 1'b1;
          rd_data_d = regs_d[i];
        end
      end
      if (rd_addr == PROT_ADDR) begin
        rd_hit                = 1'b1;
        rd_data_d[NREG-1:0]   = prot_d;
      end
      rd_err_d = !rd_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= RST_VAL;
      prot_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      prot_q     <= prot_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en;
      rd_err_q   <= rd_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NREG; i++) regs_flat[i*DW +: DW] = regs_q[i];
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign rd_err   = rd_err_q;
  assign wr_err   = wr_err_q;
  assign prot     = prot_q;

endmodule

// File: tb/tb_sfr_reg_file_param.sv
// Bench for sfr_reg_file_param: per-cycle scoreboard from a behavioural model plus
// per-scenario checks against fixed expected values.
module tb_sfr_reg_file_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [9:0]  wr_data;
  logic [1:0]  wr_op;
  logic [9:0]  rd_data;
  logic        rd_valid, wr_err, rd_err;
  logic [4:0]  prot;
  logic [49:0] regs_flat;

  int total = 0;
  int bad   = 0;

  sfr_reg_file_param #(
    .AW(8), .DW(10), .NREG(5), .BASE('h81), .RST_VAL(10'h000)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_op(wr_op),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .wr_err(wr_err), .rd_err(rd_err),
    .prot(prot), .regs_flat(regs_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [9:0]  data;
    bit          err;
    bit          werr;
    logic [4:0]  prot;
    logic [49:0] flat;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  bit         mon_en = 1'b0;
  logic [9:0] m_regs [5];
  logic [4:0] m_prot;
  logic [9:0] m_rd;

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_regs[i] = 10'h000;
    m_prot = 5'h00;
    m_rd   = 10'h000;
  endtask

  // One cycle of stimulus; the model's expected outputs for that cycle go to the scoreboard.
  task automatic drive(input bit we, input logic [7:0] wa, input logic [9:0] wd,
                       input logic [1:0] op, input bit re, input logic [7:0] ra);
    exp_t x;
    int   wi, ri;
    @(negedge clk);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_op = op; rd_en = re; rd_addr = ra;
    x.werr = 1'b0;
    if (we) begin
      if (wa >= 8'h81 && wa <= 8'h85) begin
        wi = int'(wa) - 'h81;
        if (m_prot[wi]) x.werr = 1'b1;
        else begin
          case (op)
            2'b00:   m_regs[wi] = wd;
            2'b01:   m_regs[wi] = m_regs[wi] | wd;
            2'b10:   m_regs[wi] = m_regs[wi] & ~wd;
            default: m_regs[wi] = m_regs[wi] ^ wd;
          endcase
        end
      end else if (wa == 8'h86) begin
        m_prot = m_prot | wd[4:0];
      end else begin
        x.werr = 1'b1;
      end
    end
    if (re) begin
      x.valid = 1'b1;
      x.err   = 1'b0;
      if (ra >= 8'h81 && ra <= 8'h85) begin
        ri     = int'(ra) - 'h81;
        x.data = m_regs[ri];
      end else if (ra == 8'h86) begin
        x.data = {5'b0, m_prot};
      end else begin
        x.data = 10'h000;
        x.err  = 1'b1;
      end
      m_rd = x.data;
    end else begin
      x.valid = 1'b0;
      x.err   = 1'b0;
      x.data  = m_rd;
    end
    x.prot = m_prot;
    for (int i = 0; i < 5; i++) x.flat[i*10 +: 10] = m_regs[i];
    sb.push_back(x);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 10'h000, 2'b00, 1'b0, 8'h00);
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (rd_valid !== e.valid) begin
        bad++; $display("FAIL sb_rd_valid got=%0b exp=%0b t=%0t", rd_valid, e.valid, $time);
      end
      total++;
      if (rd_data !== e.data) begin
        bad++; $display("FAIL sb_rd_data got=%h exp=%h t=%0t", rd_data, e.data, $time);
      end
      total++;
      if (rd_err !== e.err) begin
        bad++; $display("FAIL sb_rd_err got=%0b exp=%0b t=%0t", rd_err, e.err, $time);
      end
      total++;
      if (wr_err !== e.werr) begin
        bad++; $display("FAIL sb_wr_err got=%0b exp=%0b t=%0t", wr_err, e.werr, $time);
      end
      total++;
      if (prot !== e.prot) begin
        bad++; $display("FAIL sb_prot got=%h exp=%h t=%0t", prot, e.prot, $time);
      end
      total++;
      if (regs_flat !== e.flat) begin
        bad++; $display("FAIL sb_regs_flat got=%h exp=%h t=%0t", regs_flat, e.flat, $time);
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_op = '0; rd_en = 1'b0; rd_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    total++;
    if (regs_flat !== 50'h0 || prot !== 5'h00 || rd_valid !== 1'b0 || rd_data !== 10'h000 ||
        wr_err !== 1'b0 || rd_err !== 1'b0) begin
      bad++; $display("FAIL reset_state flat=%h prot=%h rv=%0b rd=%h we=%0b re=%0b exp all zero",
                      regs_flat, prot, rd_valid, rd_data, wr_err, rd_err);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic test_ops();
    logic [1:0] ops  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [9:0] opnd [4] = '{10'h2AA, 10'h055, 10'h00F, 10'h3FF};
    logic [9:0] expv [4] = '{10'h2AA, 10'h2FF, 10'h2F0, 10'h10F};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'h82, opnd[k], ops[k], 1'b0, 8'h00);
      @(posedge clk); #2;
      total++;
      if (regs_flat[19:10] !== expv[k]) begin
        bad++; $display("FAIL op%0d_flat got=%h exp=%h", k, regs_flat[19:10], expv[k]);
      end
      drive(1'b0, 8'h00, 10'h000, 2'b00, 1'b1, 8'h82);
      @(posedge clk); #2;
      total++;
      if (rd_data !== expv[k] || rd_valid !== 1'b1) begin
        bad++; $display("FAIL op%0d_read got=%h/%0b exp=%h/1", k, rd_data, rd_valid, expv[k]);
      end
    end
    idle();
  endtask

  task automatic test_protect();
    drive(1'b1, 8'h84, 10'h155, 2'b00, 1'b0, 8'h00);
    drive(1'b1, 8'h86, 10'h008, 2'b10, 1'b0, 8'h00);
    @(posedge clk); #2;
    total++;
    if (prot !== 5'h08) begin
      bad++; $display("FAIL prot_set got=%h exp=08", prot);
    end
    drive(1'b1, 8'h84, 10'h000, 2'b00, 1'b0, 8'h00);
    @(posedge clk); #2;
    total++;
    if (wr_err !== 1'b1 || regs_flat[39:30] !== 10'h155) begin
      bad++; $display("FAIL prot_reject wr_err=%0b reg=%h exp 1/155", wr_err, regs_flat[39:30]);
    end
    drive(1'b1, 8'h86, 10'h000, 2'b00, 1'b0, 8'h00);
    @(posedge clk); #2;
    total++;
    if (prot !== 5'h08 || wr_err !== 1'b0) begin
      bad++; $display("FAIL prot_sticky prot=%h wr_err=%0b exp 08/0", prot, wr_err);
    end
    idle();
  endtask

  task automatic test_bypass();
    drive(1'b1, 8'h81, 10'h3C3, 2'b00, 1'b1, 8'h81);
    @(posedge clk); #2;
    total++;
    if (rd_data !== 10'h3C3 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL bypass_write got=%h/%0b exp=3c3/1", rd_data, rd_valid);
    end
    drive(1'b1, 8'h84, 10'h000, 2'b00, 1'b1, 8'h84);
    @(posedge clk); #2;
    total++;
    if (rd_data !== 10'h155 || wr_err !== 1'b1) begin
      bad++; $display("FAIL bypass_protected got=%h werr=%0b exp=155/1", rd_data, wr_err);
    end
    drive(1'b1, 8'h85, 10'h0F0, 2'b01, 1'b1, 8'h85);
    idle();
  endtask

  task automatic test_unmapped();
    logic [7:0]  ua [3] = '{8'h80, 8'h87, 8'hFF};
    logic [49:0] flat_before;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 8'h00, 10'h000, 2'b00, 1'b1, ua[k]);
      @(posedge clk); #2;
      total++;
      if (rd_data !== 10'h000 || rd_err !== 1'b1 || rd_valid !== 1'b1) begin
        bad++; $display("FAIL unmapped_rd%0d rd=%h err=%0b v=%0b exp 000/1/1",
                        k, rd_data, rd_err, rd_valid);
      end
    end
    drive(1'b0, 8'h00, 10'h000, 2'b00, 1'b1, 8'h86);
    @(posedge clk); #2;
    total++;
    if (rd_data !== 10'h008 || rd_err !== 1'b0) begin
      bad++; $display("FAIL prot_read got=%h err=%0b exp=008/0", rd_data, rd_err);
    end
    flat_before = regs_flat;
    drive(1'b1, 8'h90, 10'h3FF, 2'b00, 1'b0, 8'h00);
    @(posedge clk); #2;
    total++;
    if (wr_err !== 1'b1 || regs_flat !== flat_before) begin
      bad++; $display("FAIL unmapped_wr werr=%0b flat=%h exp 1/%h", wr_err, regs_flat, flat_before);
    end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [9:0] expv [5] = '{10'h3C3, 10'h10F, 10'h1A5, 10'h155, 10'h0F0};
    drive(1'b1, 8'h83, 10'h1A5, 2'b00, 1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 8'h00, 10'h000, 2'b00, 1'b1, 8'(8'h81 + k));
      @(posedge clk); #2;
      total++;
      if (rd_data !== expv[k] || rd_valid !== 1'b1) begin
        bad++; $display("FAIL stream%0d got=%h/%0b exp=%h/1", k, rd_data, rd_valid, expv[k]);
      end
    end
    for (int k = 0; k < 5; k++)
      drive(1'b1, 8'(8'h81 + k), 10'h0C3, 2'(k % 4), 1'b1, 8'(8'h85 - k));
    idle();
    idle();
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 8'h00, 10'h000, 2'b00, 1'b1, 8'h82);
    @(posedge clk); #3;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    sb.delete();
    rd_en = 1'b0; wr_en = 1'b0;
    #1;
    total++;
    if (rd_valid !== 1'b0 || regs_flat !== 50'h0 || prot !== 5'h00 || rd_data !== 10'h000) begin
      bad++; $display("FAIL reset_async rv=%0b flat=%h prot=%h rd=%h exp all zero",
                      rd_valid, regs_flat, prot, rd_data);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    total++;
    if (rd_valid !== 1'b0 || wr_err !== 1'b0 || rd_err !== 1'b0) begin
      bad++; $display("FAIL reset_no_pulse rv=%0b we=%0b re=%0b exp 0/0/0", rd_valid, wr_err, rd_err);
    end
    mon_en = 1'b1;
    drive(1'b0, 8'h00, 10'h000, 2'b00, 1'b1, 8'h83);
    @(posedge clk); #2;
    total++;
    if (rd_data !== 10'h000 || rd_valid !== 1'b1) begin
      bad++; $display("FAIL reset_read got=%h/%0b exp=000/1", rd_data, rd_valid);
    end
    idle();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ops();
    test_protect();
    test_bypass();
    test_unmapped();
    test_back_to_back();
    test_reset_mid();
    @(posedge clk); #2;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
